// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller sitting in front of the core's 5-bit INT input.
// Raw asynchronous requests are synchronized, latched into PEND (level or rising-edge per
// source), masked by EN and registered onto INT. Software accesses the register window on the
// data-memory bus.
//
// Ports:
//   clk   system clock (shared with the core)
//   rst   synchronous active-high reset
//   irq   raw peripheral requests, bit i = source i (asynchronous)
//   addr  bus byte address
//   we    bus write strobe
//   wd    bus write data
//   rd    combinational read data, 0 when the window is not selected
//   sel   window select, addr[31:8] == BASE[31:8]
//   INT   registered interrupt lines to the core, unused upper bits tied 0
//
// Register map (offset = addr[7:0], addr[1:0] ignored):
//   0x00 PEND (ro), 0x04 EN (rw), 0x08 MODE (rw, 1 = edge), 0x0C ACK (w1c, reads 0), 0x10 ID (ro)
//
// N_SRC must be in 1..5 because INT is 5 bits wide.

module irq_ctrl #(
  parameter int unsigned N_SRC = 5,
  parameter logic [31:0] BASE  = 32'h0000_FF00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic [31:0]      addr,
  input  logic             we,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic             sel,
  output logic [4:0]       INT
);

  localparam logic [5:0] OffPend = 6'h00;
  localparam logic [5:0] OffEn   = 6'h01;
  localparam logic [5:0] OffMode = 6'h02;
  localparam logic [5:0] OffAck  = 6'h03;
  localparam logic [5:0] OffId   = 6'h04;

  logic [N_SRC-1:0] s1_q, s2_q, prev_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] en_q, en_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [4:0]       int_q, int_d;

  logic [5:0] off;
  logic       wr;
  logic       en_wr, mode_wr, ack_wr;
  logic [2:0] id;

  // Address bits [1:0] and write data above N_SRC have no effect.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wd};

  assign sel     = (addr[31:8] == BASE[31:8]);
  assign off     = addr[7:2];
  assign wr      = we && sel;
  assign en_wr   = wr && (off == OffEn);
  assign mode_wr = wr && (off == OffMode);
  assign ack_wr  = wr && (off == OffAck);

  // Next PEND per source. A MODE change flushes the bit so a stale level/edge state never
  // survives a mode switch; in edge mode a new edge beats a simultaneous ACK.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (mode_wr && (wd[i] != mode_q[i])) begin
        pend_d[i] = 1'b0;
      end else if (!mode_q[i]) begin
        pend_d[i] = s2_q[i];
      end else if (s2_q[i] && !prev_q[i]) begin
        pend_d[i] = 1'b1;
      end else if (ack_wr && wd[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    en_d   = en_wr   ? wd[N_SRC-1:0] : en_q;
    mode_d = mode_wr ? wd[N_SRC-1:0] : mode_q;
  end

  always_comb begin
    int_d = '0;
    int_d[N_SRC-1:0] = pend_q & en_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= '0;
      int_q  <= '0;
    end else begin
      s1_q   <= irq;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      pend_q <= pend_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      int_q  <= int_d;
    end
  end

  assign INT = int_q;

  // Lowest-numbered active source wins; scanning downward leaves the lowest match last.
  always_comb begin
    id = 3'd0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (pend_q[i] && en_q[i]) begin
        id = 3'(i + 1);
      end
    end
  end

  always_comb begin
    rd = '0;
    if (sel) begin
      unique case (off)
        OffPend: rd[N_SRC-1:0] = pend_q;
        OffEn:   rd[N_SRC-1:0] = en_q;
        OffMode: rd[N_SRC-1:0] = mode_q;
        OffId:   rd[2:0]       = id;
        default: rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios with literal expectations plus a randomized
// phase, all cross-checked every cycle against a behavioural model of the controller.

module tb_irq_ctrl;

  localparam logic [31:0] BASE = 32'h0000_FF00;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  irq;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic [4:0]  int_lines;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(
    .N_SRC(5),
    .BASE (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .irq (irq),
    .addr(addr),
    .we  (we),
    .wd  (wd),
    .rd  (rd),
    .sel (sel),
    .INT (int_lines)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[j] = irq as sampled (j+1) edges ago; the synchronizer makes PEND see the value
  // sampled two edges ago, with the one before that used for edge detection.
  logic [4:0] m_pend, m_en, m_mode, m_int;
  logic [4:0] hist [0:2];
  logic [4:0] m_lvl, m_rise, m_ack, m_chg;
  logic       m_hit;
  logic [7:0] m_off;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = '0; m_en = '0; m_mode = '0; m_int = '0;
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
    end else begin
      m_hit  = we && (addr[31:8] == BASE[31:8]);
      m_off  = addr[7:0] & 8'hFC;
      m_lvl  = hist[1];
      m_rise = hist[1] & ~hist[2];
      m_ack  = (m_hit && m_off == 8'h0C) ? wd[4:0] : 5'd0;
      m_chg  = (m_hit && m_off == 8'h08) ? (wd[4:0] ^ m_mode) : 5'd0;
      m_int  = m_pend & m_en;
      m_pend = ((~m_mode & m_lvl) | (m_mode & (m_rise | (m_pend & ~m_ack)))) & ~m_chg;
      if (m_hit && m_off == 8'h04) m_en = wd[4:0];
      if (m_hit && m_off == 8'h08) m_mode = wd[4:0];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = irq;
    end
  end

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [4:0] act;
    logic [31:0] r;
    r = 32'd0;
    act = m_pend & m_en;
    if (a[31:8] == BASE[31:8]) begin
      case (a[7:0] & 8'hFC)
        8'h00: r = {27'd0, m_pend};
        8'h04: r = {27'd0, m_en};
        8'h08: r = {27'd0, m_mode};
        8'h10: begin
          for (int i = 4; i >= 0; i--) if (act[i]) r = i + 1;
        end
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  // Per-cycle compare, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    chk("model_int", {27'd0, int_lines}, {27'd0, m_int});
    chk("model_sel", {31'd0, sel}, {31'd0, (addr[31:8] == BASE[31:8])});
    chk("model_rd", rd, model_rd(addr));
  end

  // ---------------- directed helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    addr = BASE | {24'd0, off};
    wd   = data;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
    addr = 32'd0;
    wd   = 32'd0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    addr = BASE | {24'd0, off};
    #1;
    chk(name, rd, exp);
    addr = 32'd0;
  endtask

  task automatic int_chk(input string name, input logic [4:0] exp);
    chk(name, {27'd0, int_lines}, {27'd0, exp});
  endtask

  initial begin
    rst = 1'b1; irq = 5'h1F; addr = 32'd0; we = 1'b0; wd = 32'd0;

    // Reset / idle
    tick(2);
    int_chk("rst_int", 5'h00);
    rd_chk("rst_pend", 8'h00, 32'h0);
    rd_chk("rst_en", 8'h04, 32'h0);
    rd_chk("rst_mode", 8'h08, 32'h0);
    rd_chk("rst_id", 8'h10, 32'h0);
    rst = 1'b0;
    tick(3);
    rd_chk("lvl_pend_follows", 8'h00, 32'h1F);
    int_chk("lvl_int_masked", 5'h00);
    rd_chk("lvl_id_masked", 8'h10, 32'h0);

    // Edge latency
    irq = 5'h00;
    tick(4);
    wr(8'h04, 32'h1F);
    wr(8'h08, 32'h1F);
    irq = 5'h04;
    tick(1); rd_chk("edge_e1", 8'h00, 32'h0);
    tick(1); rd_chk("edge_e2", 8'h00, 32'h0);
    tick(1); rd_chk("edge_e3_pend", 8'h00, 32'h04);
    int_chk("edge_e3_int", 5'h00);
    tick(1); int_chk("edge_e4_int", 5'b00100);
    rd_chk("edge_id", 8'h10, 32'd3);
    tick(6);
    irq = 5'h00;
    tick(5);
    rd_chk("edge_hold_pend", 8'h00, 32'h04);
    int_chk("edge_hold_int", 5'b00100);

    // ACK race
    wr(8'h0C, 32'h04);
    irq = 5'h01;
    tick(4);
    rd_chk("race_pend0", 8'h00, 32'h01);
    irq = 5'h00;
    tick(2);
    irq = 5'h01;
    tick(2);
    wr(8'h0C, 32'h01);
    rd_chk("race_set_wins", 8'h00, 32'h01);
    wr(8'h0C, 32'h01);
    rd_chk("ack_clears", 8'h00, 32'h00);
    int_chk("ack_int_k", 5'h01);
    tick(1);
    int_chk("ack_int_k1", 5'h00);

    // Priority / mask
    irq = 5'h00;
    tick(3);
    irq = 5'h0A;
    tick(4);
    rd_chk("prio_pend", 8'h00, 32'h0A);
    rd_chk("prio_id2", 8'h10, 32'd2);
    wr(8'h04, 32'h08);
    rd_chk("mask_id4", 8'h10, 32'd4);
    int_chk("mask_int_old", 5'h0A);
    tick(1);
    int_chk("mask_int_new", 5'b01000);
    rd_chk("mask_pend_kept", 8'h00, 32'h0A);

    // Level mode, ACK ignored
    irq = 5'h00;
    wr(8'h08, 32'h00);
    wr(8'h04, 32'h01);
    tick(4);
    int_chk("lvl_idle", 5'h00);
    for (int j = 1; j <= 12; j++) begin
      irq = (j <= 6) ? 5'h01 : 5'h00;
      if (j == 5) begin
        addr = BASE | 32'h0C; wd = 32'h01; we = 1'b1;
      end else begin
        addr = 32'd0; wd = 32'd0; we = 1'b0;
      end
      @(negedge clk);
      int_chk($sformatf("lvl_track_%0d", j), (j >= 4 && j <= 9) ? 5'h01 : 5'h00);
    end
    we = 1'b0; addr = 32'd0;

    // Decode
    addr = 32'h0001_FF04; wd = 32'hFFFF_FFFF; we = 1'b1;
    #1;
    chk("dec_sel_off", {31'd0, sel}, 32'd0);
    chk("dec_rd_off", rd, 32'd0);
    @(negedge clk);
    we = 1'b0;
    rd_chk("dec_en_unchanged", 8'h04, 32'h01);
    wr(8'h04, 32'hFFFF_FFFF);
    rd_chk("dec_en_written", 8'h04, 32'h1F);
    rd_chk("dec_hole", 8'h14, 32'h0);
    addr = BASE | 32'h14;
    #1;
    chk("dec_sel_on", {31'd0, sel}, 32'd1);
    addr = 32'd0;

    // Randomized phase; the per-cycle compare does the checking.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (($urandom_range(0, 3)) == 0) irq = irq ^ 5'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      we  = ($urandom_range(0, 2) == 0);
      wd  = $urandom;
      case ($urandom_range(0, 7))
        0: addr = BASE | 32'h00;
        1: addr = BASE | 32'h04;
        2: addr = ($urandom_range(0, 3) == 0) ? (BASE | 32'h08) : (BASE | 32'h04);
        3: addr = BASE | 32'h0C;
        4: addr = BASE | 32'h10;
        5: addr = BASE | {24'd0, 8'($urandom)};
        6: addr = $urandom;
        default: addr = BASE | 32'h0C;
      endcase
      addr[1:0] = 2'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; we = 1'b0; addr = 32'd0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller directly upstream of the mips core.
- Collects asynchronous peripheral interrupt requests, then synchronizes, latches, masks and prioritizes them.
- Drives the core's 5-bit INT input.
- Software reaches it on the data-memory bus: alu_out as address, wd_dm and we_dm for writes; read data is muxed into rd_dm by the system top.

Parameters:
- N_SRC, 5: number of interrupt sources; must be 1..5, since the core's INT input is 5 bits.
- BASE, 32'h0000_FF00: base byte address of the register window; bits [7:0] are ignored.

Ports:
- clk  input  1  system clock, same clock as the mips core.
- rst  input  1  reset, synchronous and active-high.
- irq  input  N_SRC  raw peripheral requests; asynchronous; bit i = source i.
- addr  input  32  bus byte address, from core alu_out.
- we  input  1  bus write strobe, from core we_dm.
- wd  input  32  bus write data, from core wd_dm.
- rd  output  32  bus read data; combinational; 0 when not selected.
- sel  output  1  high when addr[31:8] == BASE[31:8]; top uses it to steer rd into rd_dm.
- INT  output  5  registered interrupt lines to core; bits above N_SRC-1 tied 0.

Behaviour:
- Reset (rst high at clk edge):
  - sync stages, prev, PEND, EN, MODE and INT all become 0.
  - rd is 0 while sel is low.
  - Reset mid-operation discards every pending request in the same edge.
- Synchronizer: per source, a 2-flop chain s1 -> s2, plus prev <= s2 for edge detection.
- Register map (offset = addr[7:0], addr[1:0] ignored; bits [31:N_SRC] read 0, writes to them ignored):
  - 0x00 PEND: read-only.
  - 0x04 EN: read/write enable mask.
  - 0x08 MODE: read/write; 1 = rising-edge, 0 = level.
  - 0x0C ACK: write-1-to-clear PEND; reads 0.
  - 0x10 ID: read-only.
  - Other offsets: read 0, writes ignored.
- Write: occurs on the clk edge when we && sel.
- PEND next value, per bit i, evaluated in priority order:
  - MODE[i]=0 (level): PEND[i] <= s2[i]. ACK writes have no effect.
  - MODE[i]=1 (edge), set term: s2[i] & ~prev[i] sets PEND[i].
  - MODE[i]=1 (edge), clear term: an ACK write with wd[i]=1 clears PEND[i].
  - Set and clear in the same cycle: set wins, PEND[i] stays 1.
  - MODE write that changes MODE[i]: PEND[i] <= 0 on that edge. This overrides both the set and clear terms.
- INT <= PEND & EN, registered. No other state is involved.
- ID: combinational. ID = (lowest index i with PEND[i] & EN[i]) + 1, or 0 if none; 3-bit value zero-extended to 32.
- Latency, edge mode with EN set:
  - irq rises before edge 1.
  - s1 at edge 1, s2 at edge 2.
  - PEND at edge 3.
  - INT at edge 4.
  - Level mode has the same 4-edge latency. Deassert propagates with the same latency.
- ACK write at edge k: PEND clears at edge k and INT drops at edge k+1, unless a new edge arrives in the same cycle.
- Masking: clearing EN[i] removes INT[i] one edge later but keeps PEND[i]. Re-enabling re-asserts INT[i] one edge later.
- Pulse width: irq pulses shorter than one clk period may be missed; sources must hold ≥2 cycles. An edge-mode pulse held for many cycles sets PEND exactly once.
- rd: value of the addressed register when sel is high, else 32'h0. Reads have no side effects.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst for 2 cycles with irq=5'b11111; then read offsets 0x00, 0x04, 0x08 and 0x10.
  - Required response: INT=0, all registers read 0 during and after reset; after release, level PEND follows irq but INT stays 0 because EN=0.
- Edge latency:
  - Stimulus: write EN=0x1F, MODE=0x1F; raise irq[2] before edge 1 and hold 10 cycles.
  - Required response: PEND=0x04 after edge 3; INT=5'b00100 after edge 4; ID=3; PEND remains 0x04 after irq falls.
- ACK race:
  - Stimulus: irq[0] edge pending; at edge k, write ACK=0x01 while a fresh irq[0] rising edge reaches s2 in the same cycle.
  - Required response: PEND[0] stays 1. Then ACK again with no new edge: PEND=0 at edge k', INT[0]=0 at edge k'+1.
- Priority/mask:
  - Stimulus: PEND=0x0A (sources 1 and 3) with EN=0x1F.
  - Required response: ID=2. Write EN=0x08: ID=4 and INT=5'b01000 one edge later; PEND still reads 0x0A.
- Level mode:
  - Stimulus: MODE=0, EN=0x01; toggle irq[0] high 6 cycles, then low; write ACK=0x01 while irq[0] is high.
  - Required response: INT[0] tracks irq[0] delayed 4 edges; ACK has no effect.
- Decode:
  - Stimulus: write 0xFFFF_FFFF to BASE+0x04 with addr[31:8] differing from BASE[31:8].
  - Required response: sel=0, rd=0, EN unchanged. Then write it to BASE+0x04: reads 0x0000_001F. Read BASE+0x14: 0.
